axi_rd_frame_gen: RTL



---
 rtl/axi_rd_frame_gen_if.sv | 46 ++++
 rtl/axi_rd_frame_gen.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/axi_rd_frame_gen_if.sv
// axi_rd_frame_gen_if
//   Bundles the AXI read address/data channels, the frame channel toward the
//   array read controller and the array read-return path.
//   slv : block side (axi_rd_frame_gen)
//   mst : environment side (AXI master + array controller)
//   Signals:
//     axi_araddr/axi_arlen/axi_arvalid/axi_arready   AR channel
//     axi_rdata/axi_rvalid/axi_rlast/axi_rready       R channel
//     frame_data/frame_valid/frame_ready              read frames out
//     read_finish                                     segment precharge done
//     array_rd_valid/array_rd_data                    returned array beats
interface axi_rd_frame_gen_if #(
  parameter int DATA_WIDTH  = 64,
  parameter int RADDR_WIDTH = 14,
  parameter int CADDR_WIDTH = 6,
  parameter int FRAME_WIDTH = DATA_WIDTH + RADDR_WIDTH + CADDR_WIDTH + 3
);
  logic [RADDR_WIDTH+CADDR_WIDTH+2:0] axi_araddr;
  logic [3:0]                         axi_arlen;
  logic                               axi_arvalid;
  logic                               axi_arready;
  logic [DATA_WIDTH-1:0]              axi_rdata;
  logic                               axi_rvalid;
  logic                               axi_rlast;
  logic                               axi_rready;
  logic [FRAME_WIDTH-1:0]             frame_data;
  logic                               frame_valid;
  logic                               frame_ready;
  logic                               read_finish;
  logic                               array_rd_valid;
  logic [DATA_WIDTH-1:0]              array_rd_data;

  modport slv (
    input  axi_araddr, axi_arlen, axi_arvalid, axi_rready,
           frame_ready, read_finish, array_rd_valid, array_rd_data,
    output axi_arready, axi_rdata, axi_rvalid, axi_rlast,
           frame_data, frame_valid
  );

  modport mst (
    output axi_araddr, axi_arlen, axi_arvalid, axi_rready,
           frame_ready, read_finish, array_rd_valid, array_rd_data,
    input  axi_arready, axi_rdata, axi_rvalid, axi_rlast,
           frame_data, frame_valid
  );
endinterface

// File: rtl/axi_rd_frame_gen.sv
// axi_rd_frame_gen
//   Turns one AXI read burst into per-beat read frames for the array read
//   controller, splitting at row boundaries, and returns the array data on
//   the AXI R channel through a first-word-fall-through buffer. Frames are
//   only issued while the buffer is guaranteed room for their return data.
//   Ports:
//     clk   clock
//     rstn  asynchronous active-low reset
//     bus   axi_rd_frame_gen_if.slv (AR, R, frame and array-return signals)
module axi_rd_frame_gen #(
  parameter int DATA_WIDTH  = 64,
  parameter int RADDR_WIDTH = 14,
  parameter int CADDR_WIDTH = 6,
  parameter int FRAME_WIDTH = DATA_WIDTH + RADDR_WIDTH + CADDR_WIDTH + 3,
  parameter int RBUF_DEPTH  = 16
) (
  input logic             clk,
  input logic             rstn,
  axi_rd_frame_gen_if.slv bus
);
  localparam int AW    = RADDR_WIDTH + CADDR_WIDTH + 3;
  localparam int PTR_W = (RBUF_DEPTH > 1) ? $clog2(RBUF_DEPTH) : 1;
  localparam int CNT_W = $clog2(RBUF_DEPTH) + 1;
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W+1)'(RBUF_DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, SEG_WAIT, DRAIN} state_t;

  state_t                 state_q;
  logic                   arready_q;
  logic [RADDR_WIDTH-1:0] raddr_q;
  logic [CADDR_WIDTH-1:0] caddr_q;
  logic [4:0]             beats_left_q;
  logic [4:0]             rbeats_q;
  logic                   sof_q;
  logic                   fin_seen_q;
  logic [CNT_W-1:0]       occ_q, occ_d;
  logic [CNT_W-1:0]       outst_q, outst_d;
  logic [PTR_W-1:0]       wptr_q, rptr_q;
  logic                   ovf_q;
  logic [DATA_WIDTH-1:0]  mem_q [RBUF_DEPTH];

  logic [CNT_W:0] used;
  logic           credit_ok, fvalid, frame_hs, eof;
  logic           empty, full, push, pop, wr_en;

  // Address low bits select a byte within a beat and are not needed.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^bus.axi_araddr[2:0];

  always_comb begin
    // Occupancy plus in-flight frames is the buffer space already promised.
    used      = {1'b0, occ_q} + {1'b0, outst_q};
    credit_ok = used < DEPTH_C;
    fvalid    = (state_q == ISSUE) && credit_ok;
    frame_hs  = fvalid && bus.frame_ready;
    eof       = (beats_left_q == 5'd1) || (&caddr_q);

    empty = (occ_q == '0);
    full  = (occ_q == CNT_W'(RBUF_DEPTH));
    push  = bus.array_rd_valid;
    pop   = !empty && bus.axi_rready;
    // A pop in the same cycle frees the slot the push lands in.
    wr_en = push && (!full || pop);
    occ_d = occ_q + CNT_W'(wr_en) - CNT_W'(pop);

    outst_d = outst_q;
    if (frame_hs) outst_d = outst_d + CNT_W'(1);
    if (bus.array_rd_valid && (outst_d != '0)) outst_d = outst_d - CNT_W'(1);
  end

  assign bus.axi_arready = arready_q;
  assign bus.frame_valid = fvalid;
  assign bus.frame_data  = fvalid ?
      FRAME_WIDTH'({sof_q, eof, 1'b0, raddr_q, caddr_q, {DATA_WIDTH{1'b0}}}) : '0;
  assign bus.axi_rvalid  = !empty;
  assign bus.axi_rdata   = empty ? '0 : mem_q[rptr_q];
  assign bus.axi_rlast   = !empty && (rbeats_q == 5'd1);

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wptr_q] <= bus.array_rd_data;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      arready_q    <= 1'b0;
      raddr_q      <= '0;
      caddr_q      <= '0;
      beats_left_q <= '0;
      rbeats_q     <= '0;
      sof_q        <= 1'b0;
      fin_seen_q   <= 1'b0;
      occ_q        <= '0;
      outst_q      <= '0;
      wptr_q       <= '0;
      rptr_q       <= '0;
      ovf_q        <= 1'b0;
    end else begin
      occ_q   <= occ_d;
      outst_q <= outst_d;
      if (wr_en) wptr_q <= wptr_q + PTR_W'(1);
      if (pop)   rptr_q <= rptr_q + PTR_W'(1);
      if (push && !wr_en) ovf_q <= 1'b1;
      if (pop && (rbeats_q != '0)) rbeats_q <= rbeats_q - 5'd1;

      case (state_q)
        IDLE: begin
          arready_q <= 1'b1;
          if (bus.axi_arvalid && arready_q) begin
            raddr_q      <= bus.axi_araddr[AW-1:CADDR_WIDTH+3];
            caddr_q      <= bus.axi_araddr[CADDR_WIDTH+2:3];
            beats_left_q <= {1'b0, bus.axi_arlen} + 5'd1;
            rbeats_q     <= {1'b0, bus.axi_arlen} + 5'd1;
            sof_q        <= 1'b1;
            fin_seen_q   <= 1'b0;
            arready_q    <= 1'b0;
            state_q      <= ISSUE;
          end
        end
        ISSUE: begin
          if (frame_hs) begin
            caddr_q      <= caddr_q + CADDR_WIDTH'(1);
            beats_left_q <= beats_left_q - 5'd1;
            sof_q        <= 1'b0;
            if (eof) begin
              if (beats_left_q == 5'd1) begin
                state_q <= DRAIN;
              end else begin
                // Row crossing: resume at column 0 of the next row once
                // the controller has closed the current one.
                raddr_q <= raddr_q + RADDR_WIDTH'(1);
                caddr_q <= '0;
                state_q <= SEG_WAIT;
              end
            end
          end
        end
        SEG_WAIT: begin
          if (bus.read_finish) begin
            sof_q   <= 1'b1;
            state_q <= ISSUE;
          end
        end
        DRAIN: begin
          // read_finish may precede or follow the last R beat; remember it.
          if (bus.read_finish) fin_seen_q <= 1'b1;
          if ((fin_seen_q || bus.read_finish) && (rbeats_q == '0) && empty) begin
            arready_q <= 1'b1;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  ovf_never: assert property (@(posedge clk) disable iff (!rstn) !ovf_q);

endmodule
